// File: rtl/output_arbiter_3op.sv
// Fixed-priority (LOCAL > FSM1 > FSM2) packet arbiter for a 3-requester output port.
// A connection is held until a tail flit transfers or the stall watchdog fires.
module output_arbiter_3op #(
   parameter int unsigned PORTS   = 3,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] req_i,
   input  logic [PORTS-1:0] valid_i,
   input  logic [PORTS-1:0] tail_i,
   input  logic             ready_i,
   output logic [PORTS-1:0] grant_o,
   output logic [1:0]       sel_o,
   output logic             busy_o,
   output logic             timeout_o
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e           r_state, w_state_next;
   logic [PORTS-1:0] r_grant, w_grant_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic             r_timeout, w_timeout_next;

   logic [PORTS-1:0] w_req_first;
   logic             w_xfer;
   logic             w_tail_xfer;
   logic             w_stall_limit;

   // Isolate the lowest set request bit.
   assign w_req_first   = req_i & (~req_i + PORTS'(1));

   // Grant is one-hot, so masking selects only the granted requester's signals.
   assign w_xfer        = (|(r_grant & valid_i)) & ready_i;
   assign w_tail_xfer   = w_xfer & (|(r_grant & valid_i & tail_i));
   assign w_stall_limit = (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_grant   <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_grant   <= w_grant_next;
         r_cnt     <= w_cnt_next;
         r_timeout <= w_timeout_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_grant_next   = r_grant;
      w_cnt_next     = r_cnt;
      w_timeout_next = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (|req_i) begin
               w_grant_next = w_req_first;
               w_cnt_next   = '0;
               w_state_next = StBusy;
            end
         end
         StBusy: begin
            if (w_tail_xfer) begin
               w_grant_next = '0;
               w_cnt_next   = '0;
               w_state_next = StIdle;
            end else if (w_xfer) begin
               w_cnt_next = '0;
            end else if (w_stall_limit) begin
               w_grant_next   = '0;
               w_cnt_next     = '0;
               w_timeout_next = 1'b1;
               w_state_next   = StIdle;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_next = StIdle;
            w_grant_next = '0;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_comb begin
      sel_o = 2'd0;
      if (r_grant[1]) begin
         sel_o = 2'd1;
      end else if (r_grant[2]) begin
         sel_o = 2'd2;
      end
   end

   assign grant_o   = r_grant;
   assign busy_o    = (r_state == StBusy);
   assign timeout_o = r_timeout;

endmodule
